counter_cmd_gen: RTL and testbench

COUNTER_CMD_GEN -- requirements
Module: counter_cmd_gen

---
 rtl/counter_cmd_pkg.sv | 30 +++
 rtl/btn_debounce.sv | 179 +++++++++++++++++
 rtl/counter_cmd_gen.sv | 73 +++++++
 tb/tb_counter_cmd_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/counter_cmd_pkg.sv
// counter_cmd_pkg: shared types and constants for the counter command generator.
// Contains the debounce FSM state type, the default timing constants, the
// button index map and a helper that sizes the counters.
package counter_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } btn_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int DEFAULT_HOLD_CYCLES     = 50000000;
   localparam int DEFAULT_REPEAT_CYCLES   = 10000000;

   // Button slots, shared by the generate loop and the arbiter.
   localparam int BTN_UP   = 0;
   localparam int BTN_DOWN = 1;
   localparam int BTN_LOAD = 2;
   localparam int NUM_BTNS = 3;

   // Width able to hold the value max_count itself (saturation ceiling).
   function automatic int CNT_W(input int max_count);
      int w;
      w = $clog2(max_count + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one pushbutton channel.
// Raw level -> 2-flop synchronizer -> 4-state debounce FSM -> registered
// single-cycle press event. With COUNTER_CMD_AUTOREPEAT_EN defined, a held
// button (when REPEAT_EN=1) also emits repeat events after HOLD_CYCLES and
// then every REPEAT_CYCLES while the FSM stays in PRESSED.
module btn_debounce
   import counter_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
   parameter bit REPEAT_EN       = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   output logic o_event
);

   localparam int DW = CNT_W(DEBOUNCE_CYCLES);
   // Last count value before a transition fires (count holds samples seen so far).
   localparam logic [DW-1:0] C_DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] C_DEB_MAX  = DW'(DEBOUNCE_CYCLES);

   logic          r_sync1;
   logic          r_sync2;
   btn_state_t    r_state;
   btn_state_t    w_state_next;
   logic [DW-1:0] r_cnt;
   logic [DW-1:0] w_cnt_next;
   logic [DW-1:0] w_cnt_inc;
   logic          r_press_evt;
   logic          w_press_evt_next;
   logic          w_stay_pressed;

   // Two-flop synchronizer for the asynchronous button level.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Saturating increment: the counter can never wrap back to a small value.
   assign w_cnt_inc = (r_cnt >= C_DEB_MAX) ? C_DEB_MAX : r_cnt + 1'b1;

   // Debounce FSM state, sample counter and press-event register.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_press_evt <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_press_evt <= w_press_evt_next;
      end
   end

   // Next-state logic. The sample that causes leaving IDLE/PRESSED already
   // counts as the first stable sample, so the press event registers on the
   // DEBOUNCE_CYCLES-th consecutive sample. A single-sample debounce skips the
   // intermediate wait state so that timing stays uniform.
   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_press_evt_next = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_sync2) begin
               if (C_DEB_LAST == '0) begin
                  w_state_next     = ST_PRESSED;
                  w_cnt_next       = '0;
                  w_press_evt_next = 1'b1;
               end else begin
                  w_state_next = ST_WAIT_PRESS;
                  w_cnt_next   = DW'(1);
               end
            end
         end
         ST_WAIT_PRESS: begin
            if (!r_sync2) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end else if (r_cnt >= C_DEB_LAST) begin
               w_state_next     = ST_PRESSED;
               w_cnt_next       = '0;
               w_press_evt_next = 1'b1;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         ST_PRESSED: begin
            if (!r_sync2) begin
               if (C_DEB_LAST == '0) begin
                  w_state_next = ST_IDLE;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = ST_WAIT_RELEASE;
                  w_cnt_next   = DW'(1);
               end
            end
         end
         ST_WAIT_RELEASE: begin
            // Bouncing back to 1 returns to PRESSED silently: releases never emit.
            if (r_sync2) begin
               w_state_next = ST_PRESSED;
               w_cnt_next   = '0;
            end else if (r_cnt >= C_DEB_LAST) begin
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // High on every cycle that remains in PRESSED (feeds the repeat timer).
   assign w_stay_pressed = (r_state == ST_PRESSED) && (w_state_next == ST_PRESSED);

`ifdef COUNTER_CMD_AUTOREPEAT_EN
   localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW      = CNT_W(RPT_MAX);
   localparam logic [RW-1:0] C_HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] C_RPT_LAST  = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] r_rpt_cnt;
   logic          r_rpt_active;
   logic          r_rpt_evt;

   // Hold timer, then periodic repeat timer; restarts whenever PRESSED is left.
   always_ff @(posedge clock) begin
      if (reset || !REPEAT_EN) begin
         r_rpt_cnt    <= '0;
         r_rpt_active <= 1'b0;
         r_rpt_evt    <= 1'b0;
      end else if (w_stay_pressed) begin
         r_rpt_evt <= 1'b0;
         if (!r_rpt_active) begin
            if (r_rpt_cnt >= C_HOLD_LAST) begin
               r_rpt_evt    <= 1'b1;
               r_rpt_active <= 1'b1;
               r_rpt_cnt    <= '0;
            end else begin
               r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
         end else begin
            if (r_rpt_cnt >= C_RPT_LAST) begin
               r_rpt_evt <= 1'b1;
               r_rpt_cnt <= '0;
            end else begin
               r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
         end
      end else begin
         r_rpt_cnt    <= '0;
         r_rpt_active <= 1'b0;
         r_rpt_evt    <= 1'b0;
      end
   end

   assign o_event = r_press_evt | r_rpt_evt;
`else
   // Repeat timing is not built; keep the configuration visibly consumed.
   logic w_unused_cfg;
   assign w_unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES, REPEAT_EN, w_stay_pressed};

   assign o_event = r_press_evt;
`endif

endmodule

// File: rtl/counter_cmd_gen.sv
// counter_cmd_gen: turns three raw pushbuttons (up/down/load) into registered
// single-cycle strobes for a downstream up/down counter.
// Optional auto-repeat for up/down is built when COUNTER_CMD_AUTOREPEAT_EN is defined.
module counter_cmd_gen
   import counter_cmd_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
   input  logic clock,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   input  logic btn_load,
   output logic enable,
   output logic dec,
   output logic load
);

   logic [NUM_BTNS-1:0] w_raw;
   logic [NUM_BTNS-1:0] w_event;
   logic                w_up;
   logic                w_down;
   logic                w_load;
   logic                r_enable;
   logic                r_dec;
   logic                r_load;

   assign w_raw[BTN_UP]   = btn_up;
   assign w_raw[BTN_DOWN] = btn_down;
   assign w_raw[BTN_LOAD] = btn_load;

   // One debounce channel per button; load never auto-repeats.
   generate
      for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (gi != BTN_LOAD)
         ) u_btn (
            .clock   (clock),
            .reset   (reset),
            .i_raw   (w_raw[gi]),
            .o_event (w_event[gi])
         );
      end
   endgenerate

   assign w_up   = w_event[BTN_UP];
   assign w_down = w_event[BTN_DOWN];
   assign w_load = w_event[BTN_LOAD];

   // Arbitrate same-cycle events and register the strobes: load beats
   // everything (losers are dropped), opposing up+down cancel out.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_enable <= 1'b0;
         r_dec    <= 1'b0;
         r_load   <= 1'b0;
      end else begin
         r_load   <= w_load;
         r_enable <= !w_load && (w_up ^ w_down);
         r_dec    <= !w_load && w_down && !w_up;
      end
   end

   assign enable = r_enable;
   assign dec    = r_dec;
   assign load   = r_load;

endmodule

// File: tb/tb_counter_cmd_gen.sv
// tb_counter_cmd_gen: directed bench for counter_cmd_gen with
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
// Edge numbering: inputs change 1 ns after an edge; the next rising edge is edge 1.
// Auto-repeat scenarios run only when COUNTER_CMD_AUTOREPEAT_EN is defined.
module tb_counter_cmd_gen;

   logic clock;
   logic reset;
   logic btn_up;
   logic btn_down;
   logic btn_load;
   logic enable;
   logic dec;
   logic load;

   int checks   = 0;
   int failures = 0;

   counter_cmd_gen #(
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (20),
      .REPEAT_CYCLES   (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .btn_load (btn_load),
      .enable   (enable),
      .dec      (dec),
      .load     (load)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string tag, input logic exp_en, input logic exp_dec,
                            input logic exp_ld);
      checks++;
      assert ({enable, dec, load} === {exp_en, exp_dec, exp_ld})
      else begin
         failures++;
         $error("FAIL %s observed en/dec/ld=%b%b%b expected=%b%b%b",
                tag, enable, dec, load, exp_en, exp_dec, exp_ld);
      end
   endtask

   // Run n edges; a single strobe is expected at edge strobe_at (0 = none).
   task automatic run_window(input string tag, input int n, input int strobe_at,
                             input logic exp_dec, input logic exp_ld);
      for (int k = 1; k <= n; k++) begin
         logic hit;
         tick();
         hit = (k == strobe_at);
         check_out($sformatf("%s@%0d", tag, k), hit && !exp_ld, hit && exp_dec, hit && exp_ld);
      end
   endtask

   initial begin
      logic [4:0] bounce_press;
      logic [4:0] bounce_release;
      bounce_press   = 5'b10110;   // applied MSB first: 1,0,1,1,0
      bounce_release = 5'b01001;   // applied MSB first: 0,1,0,0,1

      reset    = 1'b1;
      btn_up   = 1'b0;
      btn_down = 1'b0;
      btn_load = 1'b0;
      repeat (3) tick();
      check_out("reset_state", 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      run_window("idle", 5, 0, 1'b0, 1'b0);

      // Clean up press held: one up strobe at edge 7, nothing more.
      btn_up = 1'b1;
      run_window("up_press", 24, 7, 1'b0, 1'b0);
      btn_up = 1'b0;
      run_window("up_release", 12, 0, 1'b0, 1'b0);

      // Bouncing down press then a stable run: strobe on stable edge 7.
      for (int i = 4; i >= 0; i--) begin
         btn_down = bounce_press[i];
         tick();
         check_out($sformatf("down_bounce@%0d", 5 - i), 1'b0, 1'b0, 1'b0);
      end
      btn_down = 1'b1;
      run_window("down_press", 14, 7, 1'b1, 1'b0);
      // Bouncing release must stay silent.
      for (int i = 4; i >= 0; i--) begin
         btn_down = bounce_release[i];
         tick();
         check_out($sformatf("down_rel_bounce@%0d", 5 - i), 1'b0, 1'b0, 1'b0);
      end
      btn_down = 1'b0;
      run_window("down_release", 14, 0, 1'b0, 1'b0);

      // Load and up on the same edge: only load strobes.
      btn_up   = 1'b1;
      btn_load = 1'b1;
      run_window("up_load", 14, 7, 1'b0, 1'b1);
      btn_up   = 1'b0;
      btn_load = 1'b0;
      run_window("up_load_rel", 12, 0, 1'b0, 1'b0);

      // Up and down on the same edge: cancel.
      btn_up   = 1'b1;
      btn_down = 1'b1;
      run_window("up_down", 14, 0, 1'b0, 1'b0);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      run_window("up_down_rel", 12, 0, 1'b0, 1'b0);

      // Reset at edge 5 of an up press: fresh debounce, strobe at edge 12.
      btn_up = 1'b1;
      run_window("rst_pre", 4, 0, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_out("rst_edge5", 1'b0, 1'b0, 1'b0);
      run_window("rst_post", 15, 7, 1'b0, 1'b0);
      btn_up = 1'b0;
      run_window("rst_release", 12, 0, 1'b0, 1'b0);

`ifdef COUNTER_CMD_AUTOREPEAT_EN
      // Held up: strobes at 7, 27, 35, 43, 51, 59; none after release.
      btn_up = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         logic hit;
         tick();
         hit = (k == 7) || (k >= 27 && ((k - 27) % 8) == 0);
         check_out($sformatf("rpt_up@%0d", k), hit, 1'b0, 1'b0);
      end
      btn_up = 1'b0;
      run_window("rpt_up_rel", 15, 0, 1'b0, 1'b0);

      // Held load: a single strobe only.
      btn_load = 1'b1;
      run_window("rpt_load", 60, 7, 1'b0, 1'b1);
      btn_load = 1'b0;
      run_window("rpt_load_rel", 15, 0, 1'b0, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
